// File: rtl/input_vc_unit_if.sv
// Handshake bundle between one router input port's VC unit, its upstream link,
// the switch allocator row and the crossbar. slave = the VC unit, master = its environment.
interface input_vc_unit_if #(
    parameter int unsigned VC_NUM   = 2,
    parameter int unsigned FLIT_W   = 64,
    parameter int unsigned PORT_NUM = 5
);
    localparam int unsigned VcW   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam int unsigned PortW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

    logic [FLIT_W-1:0]               flit_in;
    logic                            flit_in_valid;
    logic [VcW-1:0]                  flit_in_vc;
    logic [PORT_NUM-1:0]             out_ready;
    logic [VC_NUM-1:0]               vc_request;
    logic [VC_NUM-1:0][PortW-1:0]    vc_target_port;
    logic [VC_NUM-1:0]               vc_grant;
    logic [FLIT_W-1:0]               flit_out;
    logic                            flit_out_valid;
    logic [PortW-1:0]                flit_out_port;
    logic                            credit_out_valid;
    logic [VcW-1:0]                  credit_out_vc;
    logic                            error;

    modport slave (
        input  flit_in, flit_in_valid, flit_in_vc, out_ready, vc_grant,
        output vc_request, vc_target_port, flit_out, flit_out_valid, flit_out_port,
               credit_out_valid, credit_out_vc, error
    );

    modport master (
        output flit_in, flit_in_valid, flit_in_vc, out_ready, vc_grant,
        input  vc_request, vc_target_port, flit_out, flit_out_valid, flit_out_port,
               credit_out_valid, credit_out_vc, error
    );
endinterface

// File: rtl/input_vc_unit.sv
// Router input-port VC unit: per-VC flit FIFOs, per-VC route latch, allocator
// request/grant row, one-cycle registered dequeue toward the crossbar plus credit return.
package noc_params;
    parameter int unsigned PORT_NUM = 5;
    typedef logic [$clog2(PORT_NUM)-1:0] port_t;
endpackage

module input_vc_unit
    import noc_params::*;
#(
    parameter int unsigned VC_NUM    = 2,
    parameter int unsigned BUF_DEPTH = 4,
    parameter int unsigned FLIT_W    = 64,
    parameter int unsigned DEST_LSB  = 56
) (
    input logic              clk,
    input logic              RST,
    input_vc_unit_if.slave   bus
);
    localparam int unsigned VcW   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam int unsigned PtrW  = $clog2(BUF_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned PortW = $bits(port_t);

    typedef enum logic [0:0] {StIdle, StActive} vc_state_e;

    logic [FLIT_W-1:0] mem_q    [VC_NUM][BUF_DEPTH];
    logic [PtrW-1:0]   rd_ptr_q [VC_NUM];
    logic [PtrW-1:0]   wr_ptr_q [VC_NUM];
    logic [CntW-1:0]   count_q  [VC_NUM];
    vc_state_e         state_q  [VC_NUM];
    vc_state_e         state_d  [VC_NUM];
    port_t [VC_NUM-1:0] target_q, target_d;

    logic [FLIT_W-1:0] head_flit [VC_NUM];
    logic [VC_NUM-1:0] empty, full, front_is_head, front_is_tail, request, drop_cand;
    logic [VC_NUM-1:0] rd_en, wr_sel, wr_en;
    logic              served_valid, drop_valid, grant_err, overflow;
    logic [VcW-1:0]    served_vc, drop_vc;

    logic [FLIT_W-1:0] flit_out_q;
    logic              flit_out_valid_q, credit_valid_q, error_q;
    port_t             flit_out_port_q;
    logic [VcW-1:0]    credit_vc_q;

    // FIFO front decode and allocator request row
    always_comb begin
        for (int v = 0; v < VC_NUM; v++) begin
            head_flit[v]     = mem_q[v][rd_ptr_q[v]];
            empty[v]         = (count_q[v] == '0);
            full[v]          = (count_q[v] == CntW'(BUF_DEPTH));
            // 00 head, 11 head_tail start a packet; 10 tail, 11 head_tail end one
            front_is_head[v] = (head_flit[v][FLIT_W-1] == head_flit[v][FLIT_W-2]);
            front_is_tail[v] = head_flit[v][FLIT_W-1];
            // Out-of-range port numbers never see credit
            request[v]       = (state_q[v] == StActive) && !empty[v] &&
                               (int'(target_q[v]) < PORT_NUM) && bus.out_ready[target_q[v]];
            drop_cand[v]     = (state_q[v] == StIdle) && !empty[v] && !front_is_head[v];
        end
    end

    // Grant resolution, stray-flit drop, FIFO read/write enables, VC state next
    always_comb begin
        served_valid = 1'b0;
        served_vc    = '0;
        drop_valid   = 1'b0;
        drop_vc      = '0;
        overflow     = 1'b0;
        for (int v = 0; v < VC_NUM; v++) begin
            if (!served_valid && bus.vc_grant[v] && request[v]) begin
                served_valid = 1'b1;
                served_vc    = VcW'(v);
            end
        end
        // A drop shares the single credit return with a grant; the grant wins and
        // the drop simply happens on a later cycle.
        for (int v = 0; v < VC_NUM; v++) begin
            if (!served_valid && !drop_valid && drop_cand[v]) begin
                drop_valid = 1'b1;
                drop_vc    = VcW'(v);
            end
        end
        grant_err = (|(bus.vc_grant & ~request)) || ($countones(bus.vc_grant) > 1);
        for (int v = 0; v < VC_NUM; v++) begin
            rd_en[v]    = (served_valid && served_vc == VcW'(v)) ||
                          (drop_valid && drop_vc == VcW'(v));
            wr_sel[v]   = bus.flit_in_valid && (bus.flit_in_vc == VcW'(v));
            wr_en[v]    = wr_sel[v] && (!full[v] || rd_en[v]);
            overflow    = overflow | (wr_sel[v] && full[v] && !rd_en[v]);
            state_d[v]  = state_q[v];
            target_d[v] = target_q[v];
            unique case (state_q[v])
                StIdle: begin
                    if (!empty[v] && front_is_head[v]) begin
                        state_d[v]  = StActive;
                        target_d[v] = head_flit[v][DEST_LSB +: PortW];
                    end
                end
                StActive: begin
                    if (rd_en[v] && front_is_tail[v]) begin
                        state_d[v] = StIdle;
                    end
                end
                default: state_d[v] = StIdle;
            endcase
        end
    end

    // Flit storage; contents need no reset since occupancy is tracked by count_q
    always_ff @(posedge clk) begin
        for (int v = 0; v < VC_NUM; v++) begin
            if (wr_en[v]) begin
                mem_q[v][wr_ptr_q[v]] <= bus.flit_in;
            end
        end
    end

    // FIFO pointers, occupancy, VC state and route latch
    always_ff @(posedge clk) begin
        for (int v = 0; v < VC_NUM; v++) begin
            if (RST) begin
                rd_ptr_q[v] <= '0;
                wr_ptr_q[v] <= '0;
                count_q[v]  <= '0;
                state_q[v]  <= StIdle;
                target_q[v] <= '0;
            end else begin
                if (wr_en[v]) wr_ptr_q[v] <= wr_ptr_q[v] + PtrW'(1);
                if (rd_en[v]) rd_ptr_q[v] <= rd_ptr_q[v] + PtrW'(1);
                if (wr_en[v] && !rd_en[v]) count_q[v] <= count_q[v] + CntW'(1);
                else if (!wr_en[v] && rd_en[v]) count_q[v] <= count_q[v] - CntW'(1);
                state_q[v]  <= state_d[v];
                target_q[v] <= target_d[v];
            end
        end
    end

    // Registered crossbar output, credit return and sticky error
    always_ff @(posedge clk) begin
        if (RST) begin
            flit_out_q       <= '0;
            flit_out_valid_q <= 1'b0;
            flit_out_port_q  <= '0;
            credit_valid_q   <= 1'b0;
            credit_vc_q      <= '0;
            error_q          <= 1'b0;
        end else begin
            flit_out_valid_q <= served_valid;
            credit_valid_q   <= served_valid | drop_valid;
            if (served_valid) begin
                flit_out_q      <= head_flit[served_vc];
                flit_out_port_q <= target_q[served_vc];
                credit_vc_q     <= served_vc;
            end else if (drop_valid) begin
                credit_vc_q     <= drop_vc;
            end
            error_q <= error_q | grant_err | overflow | drop_valid;
        end
    end

    assign bus.vc_request       = request;
    assign bus.vc_target_port   = target_q;
    assign bus.flit_out         = flit_out_q;
    assign bus.flit_out_valid   = flit_out_valid_q;
    assign bus.flit_out_port    = flit_out_port_q;
    assign bus.credit_out_valid = credit_valid_q;
    assign bus.credit_out_vc    = credit_vc_q;
    assign bus.error            = error_q;
endmodule
